// File: rtl/shift_add_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t    : controller states
//   cnt_width(): bit width of the iteration counter, enough to hold WIDTH
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_seq_if.sv
// -----------------------------------------------------------------------------
// shift_add_mult_seq_if
// Start/done handshake and operand/result bus of the sequential multiplier.
//   i_START   request, sampled only while o_READY=1
//   i_SIGNED  two's-complement mode, sampled with i_START
//   i_A, i_B  multiplicand / multiplier, sampled with i_START
//   o_READY   multiplier can accept i_START this cycle
//   o_BUSY    iteration or sign fix in progress
//   o_DONE    one-cycle pulse, o_PRODUCT updated this cycle
//   o_PRODUCT last completed product, held until the next o_DONE
// The slave modport is used by the multiplier, master by whoever drives it.
// -----------------------------------------------------------------------------
interface shift_add_mult_seq_if #(
  parameter int WIDTH = 8
) ();

  logic                   i_START;
  logic                   i_SIGNED;
  logic [WIDTH-1:0]       i_A;
  logic [WIDTH-1:0]       i_B;
  logic                   o_READY;
  logic                   o_BUSY;
  logic                   o_DONE;
  logic [2*WIDTH-1:0]     o_PRODUCT;

  modport slave (
    input  i_START, i_SIGNED, i_A, i_B,
    output o_READY, o_BUSY, o_DONE, o_PRODUCT
  );

  modport master (
    output i_START, i_SIGNED, i_A, i_B,
    input  o_READY, o_BUSY, o_DONE, o_PRODUCT
  );

endinterface

// File: rtl/shift_add_mult_seq_dp.sv
// -----------------------------------------------------------------------------
// shift_add_mult_dp
// Datapath of the sequential multiplier: multiplicand register, 2W+1-bit
// accumulator, W+1-bit adder and the final sign fix.
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_load        capture operands (magnitudes when i_signed) and sign flag
//   i_step        retire one multiplier bit (fused add + shift)
//   i_fix         write the signed/unsigned product to o_product
//   i_signed      effective signed mode for the operation being loaded
//   i_a, i_b      raw operands
//   o_product     last completed product
// -----------------------------------------------------------------------------
module shift_add_mult_dp
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_fix,
  input  logic                 i_signed,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_product
);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH-1:0] w_fixed;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exactly right when the
  // W-bit result is read as unsigned, so no extra bit is needed.
  assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? ('0 - i_a) : i_a;
  assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? ('0 - i_b) : i_b;

  // Carry is kept in the W+1-bit sum; the shift below moves it into the
  // upper half so nothing is lost.
  assign w_sum   = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
  assign w_upper = r_acc[0] ? w_sum : r_acc[2*WIDTH:WIDTH];

  // Negating zero gives zero, so a zero operand always produces +0.
  assign w_fixed = r_neg ? ('0 - r_acc[2*WIDTH-1:0]) : r_acc[2*WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
    end else if (i_load) begin
      r_mcand <= w_a_mag;
      r_acc   <= {{(WIDTH+1){1'b0}}, w_b_mag};
      r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      r_acc   <= {1'b0, w_upper, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_product <= '0;
    end else if (i_fix) begin
      r_product <= w_fixed;
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/shift_add_mult_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mult_seq
// Sequential shift-add multiplier, one multiplier bit retired per clock.
// Latency from the accepting edge to o_DONE is WIDTH+1 edges, independent of
// the data; back-to-back issue interval is WIDTH+2 cycles.
//   i_CLK    rising-edge clock
//   i_RESET  asynchronous active-high reset, aborts any operation
//   bus      handshake/operand/result bus (slave side)
// Parameters: WIDTH operand width (>=2), SIGNED_EN 0 forces unsigned mode.
//
// state  | meaning
// S_IDLE | waiting for i_START, o_READY=1
// S_CALC | shifting/adding, one bit per edge, o_BUSY=1
// S_FIX  | applying the sign to the magnitude product, o_BUSY=1
// S_DONE | o_DONE pulse, o_READY=1, may accept the next i_START
// -----------------------------------------------------------------------------
module shift_add_mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  shift_add_mult_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_signed_eff;
  logic               w_last;

  assign w_signed_eff = (SIGNED_EN != 0) && bus.i_SIGNED;
  assign w_last       = (r_cnt == CNT_W'(1));

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.i_START ? S_CALC : S_IDLE;
      S_CALC:  w_next = w_last ? S_FIX : S_CALC;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = bus.i_START ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_fix   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_load  = bus.i_START;
      end
      S_CALC: begin
        w_busy  = 1'b1;
        w_step  = 1'b1;
      end
      S_FIX: begin
        w_busy  = 1'b1;
        w_fix   = 1'b1;
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_ready = 1'b1;
        w_load  = bus.i_START;
      end
      default: ;
    endcase
  end

  // Iteration counter: loaded with WIDTH, counts down once per CALC edge.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (w_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  shift_add_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .i_clk     (i_CLK),
    .i_rst     (i_RESET),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_signed  (w_signed_eff),
    .i_a       (bus.i_A),
    .i_b       (bus.i_B),
    .o_product (bus.o_PRODUCT)
  );

  assign bus.o_READY = w_ready;
  assign bus.o_BUSY  = w_busy;
  assign bus.o_DONE  = w_done;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
module tb_shift_add_mult_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_mult_seq_if #(.WIDTH(8)) if_s ();
  shift_add_mult_seq_if #(.WIDTH(8)) if_u ();

  shift_add_mult_seq #(.WIDTH(8), .SIGNED_EN(1)) dut_s (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (if_s.slave)
  );

  shift_add_mult_seq #(.WIDTH(8), .SIGNED_EN(0)) dut_u (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (if_u.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb_s[$];
  logic [15:0] sb_u[$];

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sg);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] sp;
    if (sg) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      sp = sa * sb;
      return sp;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b, input logic sg);
    if_s.i_START = st; if_s.i_A = a; if_s.i_B = b; if_s.i_SIGNED = sg;
    if_u.i_START = st; if_u.i_A = a; if_u.i_B = b; if_u.i_SIGNED = sg;
  endtask

  // Issue one operation at the current negedge and wait (bounded) for o_DONE.
  // Returns at the negedge where o_DONE is observed.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sg,
                       input logic [15:0] es, input logic [15:0] eu,
                       output logic [15:0] gs, output logic [15:0] gu,
                       output bit to, output bit stable);
    logic [15:0] held;
    drive(1'b1, a, b, sg);
    sb_s.push_back(es);
    sb_u.push_back(eu);
    held   = if_s.o_PRODUCT;
    stable = 1'b1;
    to     = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int n = 0; n < 40; n++) begin
      if (if_s.o_DONE) begin
        to = 1'b0;
        break;
      end
      if (if_s.o_PRODUCT !== held) stable = 1'b0;
      @(negedge clk);
    end
    gs = if_s.o_PRODUCT;
    gu = if_u.o_PRODUCT;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (if_s.o_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", if_s.o_READY); end
    n_checks++; if (if_s.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if_s.o_BUSY); end
    n_checks++; if (if_s.o_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", if_s.o_DONE); end
    n_checks++; if (if_s.o_PRODUCT !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", if_s.o_PRODUCT); end
    @(negedge clk);
  endtask

  task automatic test_unsigned_timing();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [15:0] exp;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    sb_s.push_back(16'hFE01);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 8'h00, 8'h00, 1'b0);
      if (if_s.o_BUSY) busy_cnt++;
      if (if_s.o_DONE) begin done_cnt++; done_at = i; end
    end
    n_checks++; if (busy_cnt != 9) begin n_fail++; $display("FAIL timing_busy_cycles got=%0d exp=9", busy_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL timing_done_pulses got=%0d exp=1", done_cnt); end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL timing_done_edge got=%0d exp=9", done_at); end
    exp = sb_s.pop_front();
    n_checks++; if (if_s.o_PRODUCT !== exp) begin n_fail++; $display("FAIL u255x255 got=%h exp=%h", if_s.o_PRODUCT, exp); end
  endtask

  task automatic test_directed();
    logic [7:0]  ta [6] = '{8'hFD, 8'h80, 8'h80, 8'h80, 8'h80, 8'hF9};
    logic [7:0]  tb [6] = '{8'h05, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h00};
    logic        tsg[6] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [15:0] te [6] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h4000, 16'h4000, 16'h0000};
    logic [15:0] gs, gu, es, eu;
    bit to, st;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tsg[i], te[i], {8'h00, ta[i]} * {8'h00, tb[i]}, gs, gu, to, st);
      es = sb_s.pop_front();
      eu = sb_u.pop_front();
      n_checks++; if (to) begin n_fail++; $display("FAIL directed_timeout idx=%0d got=no_done exp=done", i); end
      n_checks++; if (gs !== es) begin n_fail++; $display("FAIL directed_%0d got=%h exp=%h", i, gs, es); end
      n_checks++; if (gu !== eu) begin n_fail++; $display("FAIL directed_unsbuild_%0d got=%h exp=%h", i, gu, eu); end
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned_build();
    logic [15:0] gs, gu, es, eu;
    bit to, st;
    do_op(8'hFF, 8'h02, 1'b1, 16'hFFFE, 16'h01FE, gs, gu, to, st);
    es = sb_s.pop_front();
    eu = sb_u.pop_front();
    n_checks++; if (gu !== eu) begin n_fail++; $display("FAIL signed_en0 got=%h exp=%h", gu, eu); end
    n_checks++; if (gs !== es) begin n_fail++; $display("FAIL signed_en1 got=%h exp=%h", gs, es); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    bit seen = 1'b0;
    logic [15:0] exp;
    drive(1'b1, 8'd12, 8'd13, 1'b0);
    sb_s.push_back(16'd156);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b1, 8'd99, 8'd99, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'd77, 8'd55, 1'b0);
    for (int n = 0; n < 40; n++) begin
      if (if_s.o_DONE) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    exp = sb_s.pop_front();
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ignore_timeout got=no_done exp=done"); end
    n_checks++; if (if_s.o_PRODUCT !== exp) begin n_fail++; $display("FAIL ignore_product got=%h exp=%h", if_s.o_PRODUCT, exp); end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (if_s.o_DONE) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL ignore_not_queued got=%0d exp=0", dones); end
    n_checks++; if (if_s.o_READY !== 1'b1) begin n_fail++; $display("FAIL ignore_idle_ready got=%b exp=1", if_s.o_READY); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int c1 = -1;
    int c2 = -1;
    logic [15:0] exp;
    drive(1'b1, 8'd3, 8'd4, 1'b0);
    sb_s.push_back(16'd12);
    @(negedge clk);
    drive(1'b1, 8'd7, 8'd9, 1'b0);
    sb_s.push_back(16'd63);
    for (int n = 0; n < 40; n++) begin
      if (if_s.o_DONE) begin c1 = cyc; break; end
      @(negedge clk); cyc++;
    end
    exp = sb_s.pop_front();
    n_checks++; if (if_s.o_PRODUCT !== exp) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", if_s.o_PRODUCT, exp); end
    @(negedge clk); cyc++;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++; if (if_s.o_BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_reissue_busy got=%b exp=1", if_s.o_BUSY); end
    for (int n = 0; n < 40; n++) begin
      if (if_s.o_DONE) begin c2 = cyc; break; end
      @(negedge clk); cyc++;
    end
    exp = sb_s.pop_front();
    n_checks++; if (if_s.o_PRODUCT !== exp) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", if_s.o_PRODUCT, exp); end
    n_checks++; if (c1 < 0 || c2 < 0 || (c2 - c1) != 10) begin n_fail++; $display("FAIL b2b_interval got=%0d exp=10", c2 - c1); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [15:0] gs, gu, es, eu;
    bit to, st;
    drive(1'b1, 8'h55, 8'h66, 1'b0);
    sb_s.push_back(16'h21DE);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb_s.pop_front());
    n_checks++; if (if_s.o_BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", if_s.o_BUSY); end
    n_checks++; if (if_s.o_READY !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", if_s.o_READY); end
    n_checks++; if (if_s.o_PRODUCT !== 16'h0000) begin n_fail++; $display("FAIL midrst_product got=%h exp=0000", if_s.o_PRODUCT); end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      if (if_s.o_DONE) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    do_op(8'h55, 8'h66, 1'b0, 16'h21DE, 16'h21DE, gs, gu, to, st);
    es = sb_s.pop_front();
    eu = sb_u.pop_front();
    n_checks++; if (to || gs !== es) begin n_fail++; $display("FAIL midrst_recover got=%h exp=%h", gs, es); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic        sg;
    logic [15:0] gs, gu, es, eu;
    bit to, st;
    for (int i = 0; i < 3000; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      sg = 1'($urandom);
      if (i % 16 == 0) a = 8'h80;
      if (i % 16 == 1) b = 8'h00;
      do_op(a, b, sg, model(a, b, sg), model(a, b, 1'b0), gs, gu, to, st);
      es = sb_s.pop_front();
      eu = sb_u.pop_front();
      n_checks++;
      if (to || gs !== es) begin
        n_fail++;
        $display("FAIL rand a=%h b=%h s=%b got=%h exp=%h", a, b, sg, gs, es);
      end
      n_checks++;
      if (gu !== eu) begin
        n_fail++;
        $display("FAIL rand_unsbuild a=%h b=%h got=%h exp=%h", a, b, gu, eu);
      end
      n_checks++;
      if (!st) begin
        n_fail++;
        $display("FAIL rand_stable a=%h b=%h got=changed exp=held", a, b);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_timing();
    test_directed();
    test_unsigned_build();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
